// File: rtl/ac_pkg.sv
// Shared definitions for the goto/failure table loader: sizes, markers,
// FSM encoding, write-kind encodings and the packed table entry layout.
package ac_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  localparam logic [7:0] EMPTY_CUR = 8'hFF;

  localparam logic KIND_GOTO = 1'b0;
  localparam logic KIND_FAIL = 1'b1;

  typedef enum logic [1:0] {
    ST_SCRUB  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOCKED = 2'd2
  } tw_state_e;

  // Goto fields occupy the upper 20 bits so they can be written as one group.
  typedef struct packed {
    logic [7:0] cur;
    logic [3:0] chara;
    logic [7:0] nxt;
    logic [7:0] fail;
  } tw_entry_t;

  localparam int ENTRY_W = $bits(tw_entry_t);

  function automatic tw_entry_t empty_entry();
    tw_entry_t e;
    e     = '0;
    e.cur = EMPTY_CUR;
    return e;
  endfunction

endpackage

// File: rtl/table_ram.sv
// DEPTH-entry table storage with one write port (separate enables for the
// goto group and the failure field) and a registered read port.
module table_ram #(
  parameter int DEPTH = ac_pkg::DEPTH,
  parameter int AW    = ac_pkg::AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we_goto,
  input  logic              we_fail,
  input  logic [AW-1:0]     wr_addr,
  input  ac_pkg::tw_entry_t wr_data,
  input  logic [AW-1:0]     rd_addr,
  output ac_pkg::tw_entry_t rd_data
);
  import ac_pkg::*;

  logic [19:0] goto_mem [DEPTH];
  logic [7:0]  fail_mem [DEPTH];

  tw_entry_t rd_d;
  tw_entry_t rd_q;

  always_ff @(posedge CLK) begin
    if (we_goto) begin
      goto_mem[wr_addr] <= {wr_data.cur, wr_data.chara, wr_data.nxt};
    end
    if (we_fail) begin
      fail_mem[wr_addr] <= wr_data.fail;
    end
  end

  // Same-cycle write to the read address returns the pre-write contents.
  always_comb begin
    rd_d = {goto_mem[rd_addr], fail_mem[rd_addr]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/table_writer.sv
// Loads a goto/failure table from a valid/ready stream after scrubbing it,
// seals it read-only on SEAL, and discards it on CLEAR or reset.
module table_writer #(
  parameter int DEPTH = ac_pkg::DEPTH,
  parameter int AW    = ac_pkg::AW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic          WR_KIND,
  input  logic [7:0]    WR_CUR,
  input  logic [3:0]    WR_CHARA,
  input  logic [7:0]    WR_NEXT,
  input  logic          SEAL,
  input  logic          CLEAR,
  output logic          TABLE_VALID,
  output logic [AW:0]   GOTO_COUNT,
  output logic          ERR,
  input  logic [AW-1:0] RD_ADDR,
  output logic [7:0]    RD_CUR,
  output logic [3:0]    RD_CHARA,
  output logic [7:0]    RD_NEXT,
  output logic [7:0]    RD_FAIL
);
  import ac_pkg::*;

  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE    = AW'(1);

  tw_state_e     state_q, state_d;
  logic [AW-1:0] scrub_cnt_q, scrub_cnt_d;
  logic [AW:0]   goto_count_q, goto_count_d;
  logic          err_q, err_d;

  logic          handshake;
  logic          goto_full;
  logic          fail_bad;
  logic          we_goto;
  logic          we_fail;
  logic [AW-1:0] wr_addr;
  tw_entry_t     wr_data;
  tw_entry_t     rd_data;

  assign WR_READY    = (state_q == ST_LOAD) && !err_q;
  assign TABLE_VALID = (state_q == ST_LOCKED);
  assign GOTO_COUNT  = goto_count_q;
  assign ERR         = err_q;

  assign handshake = WR_VALID && WR_READY;
  assign goto_full = (goto_count_q == FULL_COUNT);
  assign fail_bad  = (32'(WR_CUR) >= DEPTH);

  always_comb begin
    state_d      = state_q;
    scrub_cnt_d  = scrub_cnt_q;
    goto_count_d = goto_count_q;
    err_d        = err_q;
    we_goto      = 1'b0;
    we_fail      = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;

    unique case (state_q)
      ST_SCRUB: begin
        we_goto = 1'b1;
        we_fail = 1'b1;
        wr_addr = scrub_cnt_q;
        wr_data = empty_entry();
        if (scrub_cnt_q == LAST_IDX) begin
          scrub_cnt_d = '0;
          state_d     = ST_LOAD;
        end else begin
          scrub_cnt_d = scrub_cnt_q + IDX_ONE;
        end
      end

      ST_LOAD: begin
        if (handshake) begin
          if (WR_KIND == KIND_GOTO) begin
            if (goto_full) begin
              err_d = 1'b1;
            end else begin
              we_goto       = 1'b1;
              wr_addr       = goto_count_q[AW-1:0];
              wr_data.cur   = WR_CUR;
              wr_data.chara = WR_CHARA;
              wr_data.nxt   = WR_NEXT;
              goto_count_d  = goto_count_q + CNT_ONE;
            end
          end else begin
            if (fail_bad) begin
              err_d = 1'b1;
            end else begin
              we_fail      = 1'b1;
              wr_addr      = WR_CUR[AW-1:0];
              wr_data.fail = WR_NEXT;
            end
          end
        end
        // A handshake in the sealing cycle is still committed above.
        if (SEAL) begin
          state_d = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
      end

      default: begin
        state_d = ST_SCRUB;
      end
    endcase

    // CLEAR wins over everything, including a same-cycle write.
    if (CLEAR) begin
      state_d      = ST_SCRUB;
      scrub_cnt_d  = '0;
      goto_count_d = '0;
      err_d        = 1'b0;
      we_goto      = 1'b0;
      we_fail      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_SCRUB;
      scrub_cnt_q  <= '0;
      goto_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      scrub_cnt_q  <= scrub_cnt_d;
      goto_count_q <= goto_count_d;
      err_q        <= err_d;
    end
  end

  table_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .CLK    (CLK),
    .RST    (RST),
    .we_goto(we_goto),
    .we_fail(we_fail),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(RD_ADDR),
    .rd_data(rd_data)
  );

  assign RD_CUR   = rd_data.cur;
  assign RD_CHARA = rd_data.chara;
  assign RD_NEXT  = rd_data.nxt;
  assign RD_FAIL  = rd_data.fail;

endmodule

// File: tb/tb_table_writer.sv
// Scoreboard bench for table_writer: a bench-side table model predicts every
// read, expected entries are queued when a read is issued and popped on return.
module tb_table_writer;
  import ac_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_VALID;
  logic       WR_READY;
  logic       WR_KIND;
  logic [7:0] WR_CUR;
  logic [3:0] WR_CHARA;
  logic [7:0] WR_NEXT;
  logic       SEAL;
  logic       CLEAR;
  logic       TABLE_VALID;
  logic [5:0] GOTO_COUNT;
  logic       ERR;
  logic [4:0] RD_ADDR;
  logic [7:0] RD_CUR;
  logic [3:0] RD_CHARA;
  logic [7:0] RD_NEXT;
  logic [7:0] RD_FAIL;

  always #5 CLK = ~CLK;

  table_writer #(.DEPTH(32), .AW(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_KIND    (WR_KIND),
    .WR_CUR     (WR_CUR),
    .WR_CHARA   (WR_CHARA),
    .WR_NEXT    (WR_NEXT),
    .SEAL       (SEAL),
    .CLEAR      (CLEAR),
    .TABLE_VALID(TABLE_VALID),
    .GOTO_COUNT (GOTO_COUNT),
    .ERR        (ERR),
    .RD_ADDR    (RD_ADDR),
    .RD_CUR     (RD_CUR),
    .RD_CHARA   (RD_CHARA),
    .RD_NEXT    (RD_NEXT),
    .RD_FAIL    (RD_FAIL)
  );

  int total = 0;
  int bad   = 0;

  // Model: {cur,chara,next,fail} per entry, plus expected ready/count/err.
  logic [27:0] m_tab [32];
  logic        m_ready;
  int          m_count;
  logic        m_err;
  logic [27:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_scrub();
    for (int i = 0; i < 32; i++) m_tab[i] = {8'hFF, 20'h0};
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // Called in the first cycle of SCRUB; counts cycles until WR_READY rises.
  task automatic wait_scrub(input string tag);
    int n;
    n = 0;
    while (!WR_READY && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("%s_scrub_cycles", tag), n, 32);
    model_scrub();
    m_ready = 1'b1;
  endtask

  task automatic wr_ctl(input logic kind, input logic [7:0] cur, input logic [3:0] ch,
                        input logic [7:0] nx, input logic seal, input logic clr);
    check("wr_ready", {31'd0, WR_READY}, {31'd0, m_ready});
    WR_VALID = 1'b1;
    WR_KIND  = kind;
    WR_CUR   = cur;
    WR_CHARA = ch;
    WR_NEXT  = nx;
    SEAL     = seal;
    CLEAR    = clr;
    if (m_ready && !clr) begin
      if (kind == KIND_GOTO) begin
        if (m_count == 32) m_err = 1'b1;
        else begin
          m_tab[m_count][27:8] = {cur, ch, nx};
          m_count++;
        end
      end else begin
        if (cur >= 8'd32) m_err = 1'b1;
        else m_tab[cur[4:0]][7:0] = nx;
      end
    end
    tick();
    WR_VALID = 1'b0;
    SEAL     = 1'b0;
    CLEAR    = 1'b0;
    if (clr || seal || m_err) m_ready = 1'b0;
  endtask

  task automatic wr(input logic kind, input logic [7:0] cur, input logic [3:0] ch,
                    input logic [7:0] nx);
    wr_ctl(kind, cur, ch, nx, 1'b0, 1'b0);
  endtask

  task automatic rd(input int a);
    logic [27:0] got;
    sb_q.push_back(m_tab[a]);
    RD_ADDR = a[4:0];
    tick();
    got = {RD_CUR, RD_CHARA, RD_NEXT, RD_FAIL};
    check($sformatf("rd[%0d]", a), {4'd0, got}, {4'd0, sb_q.pop_front()});
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) rd(i);
  endtask

  task automatic do_clear(input string tag);
    CLEAR = 1'b1;
    tick();
    CLEAR   = 1'b0;
    m_ready = 1'b0;
    wait_scrub(tag);
  endtask

  task automatic check_status(input string tag, input logic tv, input int cnt, input logic err);
    check({tag, "_valid"}, {31'd0, TABLE_VALID}, {31'd0, tv});
    check({tag, "_count"}, {26'd0, GOTO_COUNT}, cnt);
    check({tag, "_err"}, {31'd0, ERR}, {31'd0, err});
  endtask

  initial begin
    RST = 1'b0; WR_VALID = 1'b0; WR_KIND = 1'b0; WR_CUR = '0; WR_CHARA = '0;
    WR_NEXT = '0; SEAL = 1'b0; CLEAR = 1'b0; RD_ADDR = '0;
    m_ready = 1'b0; m_count = 0; m_err = 1'b0;
    model_scrub();

    repeat (3) tick();
    check("rst_ready", {31'd0, WR_READY}, 0);
    check_status("rst", 1'b0, 0, 1'b0);
    check("rst_rd", {4'd0, RD_CUR, RD_CHARA, RD_NEXT, RD_FAIL}, 0);
    RST = 1'b1;
    wait_scrub("init");
    read_all();

    // Reference load, with an extra failure entry to make FAIL visible.
    wr(KIND_GOTO, 8'd0, 4'h1, 8'h01);
    wr(KIND_GOTO, 8'd0, 4'h2, 8'h03);
    wr(KIND_GOTO, 8'd1, 4'h3, 8'h02);
    wr(KIND_FAIL, 8'd2, 4'h0, 8'h00);
    wr(KIND_FAIL, 8'd1, 4'h0, 8'h05);
    SEAL = 1'b1;
    tick();
    SEAL = 1'b0;
    m_ready = 1'b0;
    check_status("seal", 1'b1, 3, 1'b0);
    read_all();
    wr(KIND_GOTO, 8'd9, 4'h9, 8'h09);
    wr(KIND_FAIL, 8'd4, 4'h0, 8'h44);
    check_status("locked", 1'b1, 3, 1'b0);
    rd(3);
    rd(4);

    // CLEAR together with SEAL and a live handshake.
    do_clear("clr1");
    wr(KIND_GOTO, 8'd5, 4'h5, 8'h05);
    wr_ctl(KIND_GOTO, 8'd6, 4'h6, 8'h06, 1'b1, 1'b1);
    check_status("clrseal", 1'b0, 0, 1'b0);
    wait_scrub("clr2");
    read_all();

    // Fill to capacity, including a same-cycle read/write of the next slot.
    for (int i = 0; i < 32; i++) begin
      if (i == 4) begin
        sb_q.push_back(m_tab[m_count]);
        RD_ADDR = m_count[4:0];
        wr(KIND_GOTO, i[7:0], i[3:0], 8'(i + 1));
        check("rdw_old", {4'd0, RD_CUR, RD_CHARA, RD_NEXT, RD_FAIL}, {4'd0, sb_q.pop_front()});
      end else begin
        wr(KIND_GOTO, i[7:0], i[3:0], 8'(i + 1));
      end
    end
    check_status("full", 1'b0, 32, 1'b0);
    wr(KIND_GOTO, 8'hEE, 4'hE, 8'hEE);
    check_status("ovf", 1'b0, 32, 1'b1);
    wr(KIND_FAIL, 8'd0, 4'h0, 8'h33);
    read_all();
    do_clear("clr3");

    // Out-of-range failure index.
    wr(KIND_FAIL, 8'd3, 4'h0, 8'h07);
    wr(KIND_FAIL, 8'd40, 4'h0, 8'hAA);
    check_status("failidx", 1'b0, 0, 1'b1);
    read_all();
    do_clear("clr4");

    // Asynchronous reset in the middle of a load.
    for (int i = 0; i < 5; i++) wr(KIND_GOTO, 8'(i + 16), 4'(i), 8'(i + 32));
    check_status("preload", 1'b0, 5, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("rstmid_ready", {31'd0, WR_READY}, 0);
    check_status("rstmid", 1'b0, 0, 1'b0);
    check("rstmid_rd", {4'd0, RD_CUR, RD_CHARA, RD_NEXT, RD_FAIL}, 0);
    repeat (2) tick();
    RST = 1'b1;
    m_ready = 1'b0;
    wait_scrub("rst2");
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
